// File: rtl/vend_sched.sv
// Round-robin session scheduler for a shared vending datapath: grants one panel,
// collects coins into credit, vends against a fixed price list and pays change.
module vend_sched #(
    parameter int N_PANEL = 4,
    parameter int MONEY_W = 7,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PANEL-1:0] req,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_val,
    input  logic               prod_valid,
    input  logic [2:0]         prod,
    input  logic               cancel,
    output logic [N_PANEL-1:0] grant,
    output logic               busy,
    output logic [MONEY_W-1:0] credit,
    output logic               sold,
    output logic [2:0]         sold_prod,
    output logic               deny,
    output logic               coin_reject,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_coin,
    output logic               done,
    output logic [1:0]         state_dbg
);

    localparam int PW = (N_PANEL > 1) ? $clog2(N_PANEL) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t             state_q, state_n;
    logic [TW-1:0]      timer_q, timer_n;
    logic [PW-1:0]      ptr_q, ptr_n;
    logic [PW-1:0]      gidx_q, gidx_n;
    logic [2:0]         prod_q, prod_n;
    logic [MONEY_W-1:0] credit_n;
    logic [N_PANEL-1:0] grant_n;
    logic               sold_n, deny_n, coin_reject_n, change_valid_n, done_n;
    logic [2:0]         sold_prod_n;
    logic [MONEY_W-1:0] change_coin_n;

    logic [MONEY_W:0]   sum;
    logic [MONEY_W-1:0] credit_in;
    logic               pay;
    logic [MONEY_W-1:0] pay_base;
    logic               prod_ok;
    logic               hit_any;
    logic [PW-1:0]      hit_idx;
    logic [PW-1:0]      scan_idx;
    int                 scan;

    assign state_dbg = state_q;

    function automatic logic [MONEY_W-1:0] price_of(input logic [2:0] p);
        case (p)
            3'd1:    price_of = MONEY_W'(5);
            3'd2:    price_of = MONEY_W'(10);
            3'd3:    price_of = MONEY_W'(15);
            3'd4:    price_of = MONEY_W'(20);
            default: price_of = '0;
        endcase
    endfunction

    // First requester at or after the pointer, wrapping upward.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        scan     = 0;
        scan_idx = '0;
        for (int i = 0; i < N_PANEL; i++) begin
            scan = int'(ptr_q) + i;
            if (scan >= N_PANEL) scan = scan - N_PANEL;
            scan_idx = PW'(scan);
            if (!hit_any && req[scan_idx]) begin
                hit_any = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_n        = state_q;
        timer_n        = timer_q;
        ptr_n          = ptr_q;
        gidx_n         = gidx_q;
        prod_n         = prod_q;
        credit_n       = credit;
        grant_n        = grant;
        sold_n         = 1'b0;
        sold_prod_n    = '0;
        deny_n         = 1'b0;
        coin_reject_n  = coin_valid;
        change_valid_n = 1'b0;
        change_coin_n  = '0;
        done_n         = 1'b0;
        pay            = 1'b0;
        pay_base       = credit;
        sum            = {1'b0, credit} + {1'b0, coin_val};
        credit_in      = credit;
        prod_ok        = (prod != 3'd0) && (prod <= 3'd4);

        case (state_q)
            IDLE: begin
                if (hit_any) begin
                    grant_n          = '0;
                    grant_n[hit_idx] = 1'b1;
                    gidx_n           = hit_idx;
                    credit_n         = '0;
                    timer_n          = '0;
                    state_n          = COLLECT;
                end
            end
            COLLECT: begin
                coin_reject_n = coin_valid && sum[MONEY_W];
                if (coin_valid && !sum[MONEY_W]) credit_in = sum[MONEY_W-1:0];
                credit_n = credit_in;
                // Selection sees the coin accepted on the same edge; cancel wins.
                if (cancel) begin
                    timer_n  = '0;
                    pay      = 1'b1;
                    pay_base = credit_in;
                    state_n  = CHANGE;
                end else if (prod_valid) begin
                    timer_n = '0;
                    if (prod_ok && credit_in >= price_of(prod)) begin
                        prod_n      = prod;
                        sold_n      = 1'b1;
                        sold_prod_n = prod;
                        state_n     = VEND;
                    end else begin
                        deny_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    timer_n = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timer_n  = '0;
                    pay      = 1'b1;
                    pay_base = credit_in;
                    state_n  = CHANGE;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            VEND: begin
                pay      = 1'b1;
                pay_base = credit - price_of(prod_q);
                state_n  = CHANGE;
            end
            CHANGE: begin
                if (credit == '0) begin
                    done_n  = 1'b1;
                    grant_n = '0;
                    ptr_n   = (gidx_q == PW'(N_PANEL - 1)) ? '0 : gidx_q + PW'(1);
                    state_n = IDLE;
                end else begin
                    pay = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Change coin is issued on the same edge that enters or stays in CHANGE.
        if (pay) begin
            credit_n = pay_base;
            if (pay_base >= MONEY_W'(5)) begin
                change_valid_n = 1'b1;
                change_coin_n  = MONEY_W'(5);
                credit_n       = pay_base - MONEY_W'(5);
            end else if (pay_base != '0) begin
                change_valid_n = 1'b1;
                change_coin_n  = MONEY_W'(1);
                credit_n       = pay_base - MONEY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            ptr_q        <= '0;
            gidx_q       <= '0;
            prod_q       <= '0;
            credit       <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            sold         <= 1'b0;
            sold_prod    <= '0;
            deny         <= 1'b0;
            coin_reject  <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            ptr_q        <= ptr_n;
            gidx_q       <= gidx_n;
            prod_q       <= prod_n;
            credit       <= credit_n;
            grant        <= grant_n;
            busy         <= (grant_n != '0);
            sold         <= sold_n;
            sold_prod    <= sold_prod_n;
            deny         <= deny_n;
            coin_reject  <= coin_reject_n;
            change_valid <= change_valid_n;
            change_coin  <= change_coin_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_vend_sched.sv
// Directed bench for vend_sched: a vector table of per-cycle inputs and expected
// registered outputs, plus hand-written round-robin, timeout, overflow and reset sequences.
module tb_vend_sched;
    localparam int NP = 4;
    localparam int MW = 7;
    localparam int TO = 15;
    localparam logic [1:0] S_IDLE = 2'd0, S_COL = 2'd1, S_VEND = 2'd2, S_CHG = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req;
    logic          coin_valid;
    logic [MW-1:0] coin_val;
    logic          prod_valid;
    logic [2:0]    prod;
    logic          cancel;
    logic [NP-1:0] grant;
    logic          busy;
    logic [MW-1:0] credit;
    logic          sold;
    logic [2:0]    sold_prod;
    logic          deny;
    logic          coin_reject;
    logic          change_valid;
    logic [MW-1:0] change_coin;
    logic          done;
    logic [1:0]    state_dbg;

    int errors = 0;
    int checks = 0;

    vend_sched #(.N_PANEL(NP), .MONEY_W(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .coin_valid(coin_valid), .coin_val(coin_val),
        .prod_valid(prod_valid), .prod(prod), .cancel(cancel), .grant(grant), .busy(busy),
        .credit(credit), .sold(sold), .sold_prod(sold_prod), .deny(deny),
        .coin_reject(coin_reject), .change_valid(change_valid), .change_coin(change_coin),
        .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] grant;
        logic          busy;
        logic [MW-1:0] credit;
        logic          sold;
        logic [2:0]    sold_prod;
        logic          deny;
        logic          coin_reject;
        logic          change_valid;
        logic [MW-1:0] change_coin;
        logic          done;
        logic [1:0]    st;
    } outs_t;

    typedef struct {
        logic [NP-1:0] req;
        logic          cv;
        logic [MW-1:0] cval;
        logic          pv;
        logic [2:0]    prod;
        logic          cancel;
        outs_t         exp;
    } vec_t;

    vec_t tbl[$];

    function automatic outs_t mk_out(logic [NP-1:0] g, logic [MW-1:0] cr, logic s,
                                     logic [2:0] sp, logic dn, logic rj, logic cv,
                                     logic [MW-1:0] cc, logic d, logic [1:0] st);
        outs_t o;
        o.grant = g; o.busy = (g != '0); o.credit = cr; o.sold = s; o.sold_prod = sp;
        o.deny = dn; o.coin_reject = rj; o.change_valid = cv; o.change_coin = cc;
        o.done = d; o.st = st;
        return o;
    endfunction

    function automatic vec_t mk_vec(logic [NP-1:0] r, logic cv, logic [MW-1:0] cval,
                                    logic pv, logic [2:0] p, logic c, outs_t e);
        vec_t v;
        v.req = r; v.cv = cv; v.cval = cval; v.pv = pv; v.prod = p; v.cancel = c; v.exp = e;
        return v;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.grant = grant; o.busy = busy; o.credit = credit; o.sold = sold;
        o.sold_prod = sold_prod; o.deny = deny; o.coin_reject = coin_reject;
        o.change_valid = change_valid; o.change_coin = change_coin; o.done = done;
        o.st = state_dbg;
        return o;
    endfunction

    // Qualified fields only matter alongside their valid/strobe.
    function automatic outs_t mask(outs_t o);
        outs_t m = o;
        if (m.change_valid !== 1'b1) m.change_coin = '0;
        if (m.sold !== 1'b1) m.sold_prod = '0;
        return m;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("g=%b busy=%b cr=%0d sold=%b sp=%0d deny=%b rej=%b chv=%b chc=%0d done=%b st=%0d",
                         o.grant, o.busy, o.credit, o.sold, o.sold_prod, o.deny,
                         o.coin_reject, o.change_valid, o.change_coin, o.done, o.st);
    endfunction

    task automatic check_outs(input string name, input outs_t e);
        outs_t a, em;
        a  = mask(sample());
        em = mask(e);
        checks++;
        if (a !== em) begin
            errors++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(a), fmt(em));
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [NP-1:0] r, input logic cv, input logic [MW-1:0] cval,
                         input logic pv, input logic [2:0] p, input logic c);
        req = r; coin_valid = cv; coin_val = cval; prod_valid = pv; prod = p; cancel = c;
    endtask

    task automatic idle();
        drive('0, 1'b0, '0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] exp_g;
        int sum, n, got_done;

        // Simple vend with change, stray coins outside COLLECT.
        tbl.push_back(mk_vec(4'b0001, 0, 0,  0, 0, 0, mk_out(4'b0001, 0,  0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 10, 0, 0, 0, mk_out(4'b0001, 10, 0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 5,  0, 0, 0, mk_out(4'b0001, 15, 0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  1, 2, 0, mk_out(4'b0001, 15, 1, 2, 0, 0, 0, 0, 0, S_VEND)));
        tbl.push_back(mk_vec(4'b0000, 1, 3,  0, 0, 0, mk_out(4'b0001, 0,  0, 0, 0, 1, 1, 5, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  1, 1, 1, mk_out(4'b0000, 0,  0, 0, 0, 0, 0, 0, 1, S_IDLE)));
        tbl.push_back(mk_vec(4'b0000, 1, 3,  0, 0, 0, mk_out(4'b0000, 0,  0, 0, 0, 1, 0, 0, 0, S_IDLE)));
        // Insufficient credit, then exact vend with no change.
        tbl.push_back(mk_vec(4'b0001, 0, 0,  0, 0, 0, mk_out(4'b0001, 0,  0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 7,  0, 0, 0, mk_out(4'b0001, 7,  0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  1, 4, 0, mk_out(4'b0001, 7,  0, 0, 1, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 13, 0, 0, 0, mk_out(4'b0001, 20, 0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  1, 4, 0, mk_out(4'b0001, 20, 1, 4, 0, 0, 0, 0, 0, S_VEND)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0001, 0,  0, 0, 0, 0, 0, 0, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0000, 0,  0, 0, 0, 0, 0, 0, 1, S_IDLE)));
        // Pointer now 1: panel 1 wins over panel 0; cancel with coin beats a selection.
        tbl.push_back(mk_vec(4'b0011, 0, 0,  0, 0, 0, mk_out(4'b0010, 0,  0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 12, 0, 0, 0, mk_out(4'b0010, 12, 0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 1,  1, 1, 1, mk_out(4'b0010, 8,  0, 0, 0, 0, 1, 5, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0010, 3,  0, 0, 0, 0, 1, 5, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 1, 9,  0, 0, 0, mk_out(4'b0010, 2,  0, 0, 0, 1, 1, 1, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0010, 1,  0, 0, 0, 0, 1, 1, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0010, 0,  0, 0, 0, 0, 1, 1, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0000, 0,  0, 0, 0, 0, 0, 0, 1, S_IDLE)));
        // Pointer now 2: wraps to panel 1; coin and selection in the same cycle.
        tbl.push_back(mk_vec(4'b0010, 0, 0,  0, 0, 0, mk_out(4'b0010, 0,  0, 0, 0, 0, 0, 0, 0, S_COL)));
        tbl.push_back(mk_vec(4'b0000, 1, 5,  1, 1, 0, mk_out(4'b0010, 5,  1, 1, 0, 0, 0, 0, 0, S_VEND)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0010, 0,  0, 0, 0, 0, 0, 0, 0, S_CHG)));
        tbl.push_back(mk_vec(4'b0000, 0, 0,  0, 0, 0, mk_out(4'b0000, 0,  0, 0, 0, 0, 0, 0, 1, S_IDLE)));

        do_reset();
        check_outs("reset", mk_out(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].cv, tbl[i].cval, tbl[i].pv, tbl[i].prod, tbl[i].cancel);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Round-robin with all panels requesting continuously.
        do_reset();
        for (int s = 0; s < 5; s++) begin
            exp_g = '0;
            exp_g[s % NP] = 1'b1;
            drive(4'b1111, 0, 0, 0, 0, 0);
            tick();
            check_outs($sformatf("rr_grant%0d", s), mk_out(exp_g, 0, 0, 0, 0, 0, 0, 0, 0, S_COL));
            drive(4'b1111, 0, 0, 0, 0, 1);
            tick();
            check_outs($sformatf("rr_cancel%0d", s), mk_out(exp_g, 0, 0, 0, 0, 0, 0, 0, 0, S_CHG));
            drive(4'b1111, 0, 0, 0, 0, 0);
            tick();
            check_outs($sformatf("rr_done%0d", s), mk_out(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, S_IDLE));
        end

        // Timeout refund; an invalid selection restarts the idle count.
        drive(4'b0001, 0, 0, 0, 0, 0); tick();
        check_outs("to_grant", mk_out(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 3, 0, 0, 0); tick();
        idle();
        repeat (10) tick();
        check_outs("to_idle10", mk_out(4'b0001, 3, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 0, 0, 1, 5, 0); tick();
        check_outs("to_deny", mk_out(4'b0001, 3, 0, 0, 1, 0, 0, 0, 0, S_COL));
        idle();
        repeat (14) tick();
        check_outs("to_idle14", mk_out(4'b0001, 3, 0, 0, 0, 0, 0, 0, 0, S_COL));
        tick();
        check_outs("to_fire", mk_out(4'b0001, 2, 0, 0, 0, 0, 1, 1, 0, S_CHG));
        tick();
        check_outs("to_coin2", mk_out(4'b0001, 1, 0, 0, 0, 0, 1, 1, 0, S_CHG));
        tick();
        check_outs("to_coin3", mk_out(4'b0001, 0, 0, 0, 0, 0, 1, 1, 0, S_CHG));
        tick();
        check_outs("to_done", mk_out(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, S_IDLE));

        // Credit overflow at the 127 ceiling, then a long change payout.
        drive(4'b0010, 0, 0, 0, 0, 0); tick();
        check_outs("ovf_grant", mk_out(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 100, 0, 0, 0); tick();
        drive(4'b0000, 1, 25, 0, 0, 0); tick();
        check_outs("ovf_125", mk_out(4'b0010, 125, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 5, 0, 0, 0); tick();
        check_outs("ovf_reject5", mk_out(4'b0010, 125, 0, 0, 0, 1, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 2, 0, 0, 0); tick();
        check_outs("ovf_127", mk_out(4'b0010, 127, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 0, 0, 0, 0); tick();
        check_outs("ovf_zero_coin", mk_out(4'b0010, 127, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 1, 0, 0, 0); tick();
        check_outs("ovf_reject1", mk_out(4'b0010, 127, 0, 0, 0, 1, 0, 0, 0, S_COL));
        drive(4'b0000, 0, 0, 1, 4, 0); tick();
        check_outs("ovf_sold", mk_out(4'b0010, 127, 1, 4, 0, 0, 0, 0, 0, S_VEND));
        idle();
        sum = 0; n = 0; got_done = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            tick();
            if (change_valid === 1'b1) begin
                sum += int'(change_coin);
                n++;
            end
            if (done === 1'b1) got_done = 1;
        end
        check_val("ovf_done_seen", got_done, 1);
        check_val("ovf_change_sum", sum, 107);
        check_val("ovf_change_coins", n, 23);
        tick();
        check_outs("ovf_after_done", mk_out(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // Reset while change is paying out; pointer returns to panel 0.
        drive(4'b0100, 0, 0, 0, 0, 0); tick();
        check_outs("rm_grant", mk_out(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, S_COL));
        drive(4'b0000, 1, 20, 0, 0, 0); tick();
        drive(4'b0000, 0, 0, 0, 0, 1); tick();
        check_outs("rm_pay1", mk_out(4'b0100, 15, 0, 0, 0, 0, 1, 5, 0, S_CHG));
        idle(); tick();
        check_outs("rm_pay2", mk_out(4'b0100, 10, 0, 0, 0, 0, 1, 5, 0, S_CHG));
        rst = 1'b1; tick();
        check_outs("rm_reset", mk_out(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
        rst = 1'b0;
        drive(4'b0011, 0, 0, 0, 0, 0); tick();
        check_outs("rm_ptr", mk_out(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, S_COL));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
